// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: E-stage bundle between the decode/forwarding logic and the
// multiply/divide unit.
//   A, B       rs/rt operands (post-forwarding)
//   alupro_op  0=none 1=mult 2=multu 3=div 4=divu 5=mtlo 6=mthi 7=mflo 8=mfhi
//   start      1-cycle launch pulse for ops 1..4
//   busy       operation in flight
//   md_stall   busy | start, consumed by the hazard unit
//   out        HI/LO read data for mfhi/mflo, else zero
// master = pipeline side, slave = the unit.
interface mdu_hilo_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  alupro_op;
    logic        start;
    logic        busy;
    logic        md_stall;
    logic [31:0] out;

    modport master (output A, B, alupro_op, start, input busy, md_stall, out);
    modport slave  (input A, B, alupro_op, start, output busy, md_stall, out);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO.
//   clk    rising-edge clock
//   reset  asynchronous active-low; clears HI/LO and aborts any operation
//   bus    mdu_hilo_if.slave (operands, op, start in; busy, md_stall, out out)
// mult/multu hold busy for MULT_CYC cycles and div/divu for DIV_CYC cycles.
// The result is formed combinationally from operands latched at start and is
// written to HI/LO only on the final busy edge, so an abort leaves no trace.
module mdu_hilo #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_hilo_if.slave bus
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MFHI  = 4'd8;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi, lo;
    logic [31:0]      a_q, b_q;
    logic [3:0]       op_q;
    logic             busy_q;

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        dvsr_u, abs_a, abs_b, uq, ur, mq, mr, sq, sr;
    logic               b_zero;

    // Result datapath off the latched operands. Divisors are forced to 1 when
    // B==0 so the dividers never see a zero; that result is discarded anyway.
    always_comb begin
        b_zero = (b_q == 32'd0);
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        dvsr_u = b_zero ? 32'd1 : b_q;
        uq     = a_q / dvsr_u;
        ur     = a_q % dvsr_u;
        // Signed divide on magnitudes: quotient truncates toward zero,
        // remainder takes the dividend's sign.
        abs_a  = a_q[31] ? -a_q : a_q;
        abs_b  = b_zero ? 32'd1 : (b_q[31] ? -b_q : b_q);
        mq     = abs_a / abs_b;
        mr     = abs_a % abs_b;
        sq     = (a_q[31] ^ b_q[31]) ? -mq : mq;
        sr     = a_q[31] ? -mr : mr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            op_q   <= 4'd0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && (bus.alupro_op == OP_MULT || bus.alupro_op == OP_MULTU)) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        op_q   <= bus.alupro_op;
                        cnt    <= MUL_LD;
                        busy_q <= 1'b1;
                        state  <= MUL;
                    end else if (bus.start && (bus.alupro_op == OP_DIV || bus.alupro_op == OP_DIVU)) begin
                        a_q    <= bus.A;
                        b_q    <= bus.B;
                        op_q   <= bus.alupro_op;
                        cnt    <= DIV_LD;
                        busy_q <= 1'b1;
                        state  <= DIV;
                    end else if (!bus.start && bus.alupro_op == OP_MTLO) begin
                        lo <= bus.A;
                    end else if (!bus.start && bus.alupro_op == OP_MTHI) begin
                        hi <= bus.A;
                    end
                end
                MUL, DIV: begin
                    // start/mtlo/mthi are deliberately not looked at here.
                    if (cnt == CNT_ONE) begin
                        case (op_q)
                            OP_MULT:  {hi, lo} <= prod_s;
                            OP_MULTU: {hi, lo} <= prod_u;
                            OP_DIV:   if (!b_zero) begin lo <= sq; hi <= sr; end
                            OP_DIVU:  if (!b_zero) begin lo <= uq; hi <= ur; end
                            default:  ;
                        endcase
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.md_stall = busy_q | bus.start;
    assign bus.out      = (bus.alupro_op == OP_MFHI) ? hi :
                          (bus.alupro_op == OP_MFLO) ? lo : 32'd0;
endmodule
